// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified instruction/data memory arbiter.
package mem_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  localparam logic GNT_IF   = 1'b0;
  localparam logic GNT_DATA = 1'b1;

  localparam int unsigned LAT_W = 4;

endpackage

// File: rtl/mem_lat_timer.sv
// Loadable down-counter that times the fixed memory latency; done marks the last cycle.
module mem_lat_timer
  import mem_arb_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [LAT_W-1:0] value,
  output logic             done
);

  logic [LAT_W-1:0] lat_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lat_cnt <= '0;
    end else if (load) begin
      lat_cnt <= value;
    end else if (lat_cnt != '0) begin
      lat_cnt <= lat_cnt - LAT_W'(1);
    end
  end

  assign done = (lat_cnt == LAT_W'(1));

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store,
// with data priority, a bounded data streak, and fetch kill handling.
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned MEM_LAT         = 2,
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_kill,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_ready,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              if_stall,
  output logic              mem_stall,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int unsigned STREAK_W = $clog2(MAX_DATA_STREAK + 1);

  arb_state_t          state;
  logic                gnt_data;
  logic                gnt_we;
  logic                kill_pend;
  logic [STREAK_W-1:0] streak;

  logic issue;
  logic pick_if;
  logic lat_done;
  logic complete;
  logic fetch_killed;

  // Data wins unless a waiting fetch has already been passed over too often.
  assign pick_if = if_req & (~mem_req | (streak == STREAK_W'(MAX_DATA_STREAK)));
  assign issue   = ~reset & (state == ARB_IDLE) & (if_req | mem_req);

  assign ram_en    = issue;
  assign ram_we    = issue & ~pick_if & mem_we;
  assign ram_addr  = issue ? (pick_if ? if_addr : mem_addr) : '0;
  assign ram_wdata = (issue & ~pick_if) ? mem_wdata : '0;

  mem_lat_timer u_timer (
    .clock (clock),
    .reset (reset),
    .load  (issue),
    .value (LAT_W'(MEM_LAT)),
    .done  (lat_done)
  );

  assign complete     = (state == ARB_BUSY) & lat_done;
  assign fetch_killed = kill_pend | if_kill;

  assign if_ready  = complete & (gnt_data == GNT_IF) & ~fetch_killed;
  assign mem_ready = complete & (gnt_data == GNT_DATA);
  assign if_rdata  = if_ready ? ram_rdata : '0;
  // A store has no read data to return.
  assign mem_rdata = (mem_ready & ~gnt_we) ? ram_rdata : '0;

  assign if_stall  = ~reset & if_req & ~if_ready;
  assign mem_stall = ~reset & mem_req & ~mem_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ARB_IDLE;
      gnt_data  <= GNT_IF;
      gnt_we    <= 1'b0;
      kill_pend <= 1'b0;
      streak    <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (issue) begin
            state     <= ARB_BUSY;
            gnt_data  <= pick_if ? GNT_IF : GNT_DATA;
            gnt_we    <= ~pick_if & mem_we;
            kill_pend <= 1'b0;
            if (pick_if || !if_req) begin
              streak <= '0;
            end else if (streak != STREAK_W'(MAX_DATA_STREAK)) begin
              streak <= streak + STREAK_W'(1);
            end
          end
        end
        ARB_BUSY: begin
          if ((gnt_data == GNT_IF) && if_kill) begin
            kill_pend <= 1'b1;
          end
          if (lat_done) begin
            state <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter with MEM_LAT=2 and MAX_DATA_STREAK=2.
module tb_unified_mem_arbiter;

  logic        clock;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_kill;
  logic        if_ready;
  logic [31:0] if_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        if_stall;
  logic        mem_stall;
  logic        ram_en;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  unified_mem_arbiter #(
    .ADDR_W          (32),
    .DATA_W          (32),
    .MEM_LAT         (2),
    .MAX_DATA_STREAK (2)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_kill   (if_kill),
    .if_ready  (if_ready),
    .if_rdata  (if_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .if_stall  (if_stall),
    .mem_stall (mem_stall),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic drain();
    if_req    = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    if_kill   = 1'b0;
    repeat (3) next_cycle();
    ram_rdata = '0;
  endtask

  logic [31:0] exp_addr [6];

  initial begin
    reset     = 1'b1;
    if_req    = 1'b1;
    if_addr   = 32'h0000_0040;
    if_kill   = 1'b0;
    mem_req   = 1'b1;
    mem_we    = 1'b0;
    mem_addr  = 32'h0000_0100;
    mem_wdata = 32'hFFFF_FFFF;
    ram_rdata = '0;

    // Reset: outputs held low even with requests pending.
    next_cycle();
    #1;
    check("rst_ram_en", 64'(ram_en), 64'd0);
    check("rst_if_stall", 64'(if_stall), 64'd0);
    check("rst_mem_stall", 64'(mem_stall), 64'd0);
    check("rst_ram_addr", 64'(ram_addr), 64'd0);
    if_req  = 1'b0;
    mem_req = 1'b0;
    next_cycle();
    reset = 1'b0;
    next_cycle();
    #1;
    check("idle_ram_en", 64'(ram_en), 64'd0);

    // Fetch only.
    next_cycle();
    if_req  = 1'b1;
    if_addr = 32'h0000_0040;
    #1;
    check("f_issue_en", 64'(ram_en), 64'd1);
    check("f_issue_addr", 64'(ram_addr), 64'h40);
    check("f_issue_we", 64'(ram_we), 64'd0);
    check("f_issue_wdata", 64'(ram_wdata), 64'd0);
    next_cycle();
    #1;
    check("f_t1_en", 64'(ram_en), 64'd0);
    check("f_t1_ready", 64'(if_ready), 64'd0);
    next_cycle();
    ram_rdata = 32'h8C01_0004;
    if_addr   = 32'h0000_0044;
    #1;
    check("f_t2_ready", 64'(if_ready), 64'd1);
    check("f_t2_rdata", 64'(if_rdata), 64'h8C01_0004);
    check("f_t2_stall", 64'(if_stall), 64'd0);
    next_cycle();
    ram_rdata = '0;
    #1;
    check("f_t3_en", 64'(ram_en), 64'd1);
    check("f_t3_addr", 64'(ram_addr), 64'h44);
    next_cycle();
    drain();

    // Simultaneous fetch and load: data first.
    next_cycle();
    if_req   = 1'b1;
    if_addr  = 32'h0000_0040;
    mem_req  = 1'b1;
    mem_we   = 1'b0;
    mem_addr = 32'h0000_0100;
    #1;
    check("c_t0_addr", 64'(ram_addr), 64'h100);
    check("c_t0_if_stall", 64'(if_stall), 64'd1);
    next_cycle();
    #1;
    check("c_t1_if_stall", 64'(if_stall), 64'd1);
    next_cycle();
    ram_rdata = 32'hCAFE_0001;
    #1;
    check("c_t2_mem_ready", 64'(mem_ready), 64'd1);
    check("c_t2_mem_rdata", 64'(mem_rdata), 64'hCAFE_0001);
    check("c_t2_if_ready", 64'(if_ready), 64'd0);
    check("c_t2_if_stall", 64'(if_stall), 64'd1);
    next_cycle();
    mem_req   = 1'b0;
    ram_rdata = '0;
    #1;
    check("c_t3_en", 64'(ram_en), 64'd1);
    check("c_t3_addr", 64'(ram_addr), 64'h40);
    check("c_t3_if_stall", 64'(if_stall), 64'd1);
    next_cycle();
    #1;
    check("c_t4_if_stall", 64'(if_stall), 64'd1);
    next_cycle();
    ram_rdata = 32'h1111_2222;
    #1;
    check("c_t5_if_ready", 64'(if_ready), 64'd1);
    check("c_t5_if_rdata", 64'(if_rdata), 64'h1111_2222);
    check("c_t5_if_stall", 64'(if_stall), 64'd0);
    next_cycle();
    drain();

    // Streak fairness: both held, order D,D,I,D,D,I.
    exp_addr[0] = 32'h200;
    exp_addr[1] = 32'h200;
    exp_addr[2] = 32'h300;
    exp_addr[3] = 32'h200;
    exp_addr[4] = 32'h200;
    exp_addr[5] = 32'h300;
    next_cycle();
    if_req   = 1'b1;
    if_addr  = 32'h0000_0300;
    mem_req  = 1'b1;
    mem_we   = 1'b0;
    mem_addr = 32'h0000_0200;
    for (int g = 0; g < 6; g++) begin
      #1;
      check($sformatf("s_en_%0d", g), 64'(ram_en), 64'd1);
      check($sformatf("s_addr_%0d", g), 64'(ram_addr), 64'(exp_addr[g]));
      repeat (3) next_cycle();
    end
    drain();

    // Fetch killed in flight; redirect fetch follows.
    next_cycle();
    if_req  = 1'b1;
    if_addr = 32'h0000_0080;
    #1;
    check("k_t0_addr", 64'(ram_addr), 64'h80);
    next_cycle();
    if_kill = 1'b1;
    if_addr = 32'h0000_0400;
    next_cycle();
    if_kill   = 1'b0;
    ram_rdata = 32'hBAD0_BAD0;
    #1;
    check("k_t2_ready", 64'(if_ready), 64'd0);
    check("k_t2_rdata", 64'(if_rdata), 64'd0);
    next_cycle();
    ram_rdata = '0;
    #1;
    check("k_t3_en", 64'(ram_en), 64'd1);
    check("k_t3_addr", 64'(ram_addr), 64'h400);
    next_cycle();
    if_req = 1'b0;
    next_cycle();
    ram_rdata = 32'h0000_0AAA;
    #1;
    check("k_t5_ready", 64'(if_ready), 64'd1);
    check("k_t5_rdata", 64'(if_rdata), 64'hAAA);
    drain();

    // Store.
    next_cycle();
    mem_req   = 1'b1;
    mem_we    = 1'b1;
    mem_addr  = 32'h0000_0020;
    mem_wdata = 32'hDEAD_BEEF;
    #1;
    check("st_en", 64'(ram_en), 64'd1);
    check("st_we", 64'(ram_we), 64'd1);
    check("st_addr", 64'(ram_addr), 64'h20);
    check("st_wdata", 64'(ram_wdata), 64'hDEAD_BEEF);
    check("st_stall", 64'(mem_stall), 64'd1);
    next_cycle();
    next_cycle();
    ram_rdata = 32'h1234_5678;
    #1;
    check("st_ready", 64'(mem_ready), 64'd1);
    check("st_rdata", 64'(mem_rdata), 64'd0);
    check("st_stall_done", 64'(mem_stall), 64'd0);
    next_cycle();
    drain();

    // Reset during a load abandons it.
    next_cycle();
    mem_req  = 1'b1;
    mem_we   = 1'b0;
    mem_addr = 32'h0000_0100;
    #1;
    check("r_t0_en", 64'(ram_en), 64'd1);
    next_cycle();
    reset = 1'b1;
    #1;
    check("r_t1_en", 64'(ram_en), 64'd0);
    check("r_t1_addr", 64'(ram_addr), 64'd0);
    check("r_t1_ready", 64'(mem_ready), 64'd0);
    check("r_t1_stall", 64'(mem_stall), 64'd0);
    next_cycle();
    ram_rdata = 32'h0000_0055;
    #1;
    check("r_t2_ready", 64'(mem_ready), 64'd0);
    next_cycle();
    reset     = 1'b0;
    ram_rdata = '0;
    #1;
    check("r_t3_en", 64'(ram_en), 64'd1);
    check("r_t3_addr", 64'(ram_addr), 64'h100);
    check("r_t3_ready", 64'(mem_ready), 64'd0);
    next_cycle();
    #1;
    check("r_t4_ready", 64'(mem_ready), 64'd0);
    next_cycle();
    ram_rdata = 32'h0000_0077;
    #1;
    check("r_t5_ready", 64'(mem_ready), 64'd1);
    check("r_t5_rdata", 64'(mem_rdata), 64'h77);
    next_cycle();
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/unified_mem_arbiter.md
# unified_mem_arbiter

- Shares one single-port unified instruction/data memory between the pipeline's IF stage (fetch) and MEM stage (load/store).
- Arbitrates each access, issues a one-cycle command to the memory, and times the fixed memory latency.
- Returns a one-cycle ready pulse to the winning requester.
- Requesters stall, holding pc/IF_ID or EXE_MEM, while their request is pending.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 2, cycles from issue to read data valid (legal range 1..15)
- MAX_DATA_STREAK, 4, consecutive data grants allowed while a fetch waits (≥1)

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- if_req  in  1  fetch request, held until if_ready or if_kill
- if_addr  in  ADDR_W  fetch address (pc), stable while if_req
- if_kill  in  1  discard the in-flight fetch (branch/jump redirect, driven from IF_ID_flush)
- if_ready  out  1  fetch done; if_rdata valid this cycle
- if_rdata  out  DATA_W  instruction; 0 when if_ready=0
- mem_req  in  1  data request, held until mem_ready
- mem_we  in  1  1 = store, 0 = load
- mem_addr  in  ADDR_W  data address (MEM_c)
- mem_wdata  in  DATA_W  store data
- mem_ready  out  1  data access done
- mem_rdata  out  DATA_W  load data; 0 when mem_ready=0
- if_stall  out  1  if_req & ~if_ready
- mem_stall  out  1  mem_req & ~mem_ready
- ram_en  out  1  one-cycle command strobe
- ram_we  out  1  write enable, qualified by ram_en
- ram_addr  out  ADDR_W  command address
- ram_wdata  out  DATA_W  command write data
- ram_rdata  in  DATA_W  read data, valid MEM_LAT cycles after the ram_en edge

## Operation
- States: IDLE and BUSY. Registers: lat_cnt (4 bits), gnt_data, kill_pend, streak (width clog2(MAX_DATA_STREAK+1)).
- IDLE, no request: all ram_* outputs are 0.
- IDLE, any request: ram_en=1 combinationally, and ram_addr/ram_we/ram_wdata are muxed from the winner.
- Fetch issues always have ram_we=0 and ram_wdata=0.
- At the clock edge after an issue: state goes to BUSY, lat_cnt loads MEM_LAT, gnt_data is latched, kill_pend is cleared.
- Arbitration: data wins by default, since MEM holds the older instruction.
- Fairness exception: IF wins if both request and streak==MAX_DATA_STREAK.
- Streak update on a data grant: increments (saturating) if if_req=1 at the issue, otherwise clears to 0.
- Streak update on a fetch grant: clears to 0.
- BUSY: lat_cnt decrements every cycle. The cycle with lat_cnt==1 is the completion cycle.
  - The selected ready is asserted for that cycle only, and rdata passes ram_rdata.
  - The following edge returns the state to IDLE.
- Stores complete on the same schedule as loads (mem_ready after MEM_LAT cycles). The write is committed by the memory at the issue edge.
- if_kill while BUSY with a fetch grant, or on the completion cycle: sets or uses kill_pend, and if_ready stays 0 on completion.
  - The memory read still runs to completion and the bus is not freed early.
- if_kill in IDLE, or while BUSY with a data grant: no effect. The requester drops or changes if_req itself.
- Changing if_addr/mem_addr while BUSY has no effect on the in-flight access.
- The data port never sees a kill.

## Timing
- Reset values: state=IDLE, lat_cnt=0, streak=0, gnt_data=0, kill_pend=0.
- All outputs are 0 during reset. ram_en drops immediately because reset is asserted asynchronously.
- Reset asserted mid-BUSY abandons the access: no ready pulse is produced, and a store already issued stays committed.
- Issue in cycle t → BUSY in cycles t+1..t+MEM_LAT → ready in cycle t+MEM_LAT → next issue no earlier than t+MEM_LAT+1.
- Peak throughput: one access per MEM_LAT+1 cycles.
- The ready-to-requester path is combinational from state/lat_cnt only. There is no combinational path from if_req/mem_req to if_ready/mem_ready.
- A requester that keeps req high after its ready pulse is treated as a new request and is arbitrated in the next IDLE cycle.

## Structure
- Shared package `mem_arb_pkg`:
  - state enum (ARB_IDLE, ARB_BUSY)
  - grant constants (GNT_IF=0, GNT_DATA=1)
  - lat_cnt width constant LAT_W=4
- One natural sub-module, `mem_lat_timer`:
  - Loadable down-counter with load/value inputs and a `done` output (count==1).
  - Instantiated once.
- Arbitration, streak and kill logic stay in the top module.

## Test plan
- MEM_LAT=2, fetch only, if_addr=0x0000_0040, ram_rdata=0x8C01_0004 at the right cycle → ram_en at t; if_ready=1 and if_rdata=0x8C01_0004 at t+2; next fetch issues at t+3.
- Same-cycle if_req and mem_req (load 0x100) → data issued first. The fetch issues at t+3, and if_ready arrives at t+5. if_stall is high t..t+4.
- MAX_DATA_STREAK=2, if_req held while mem_req is re-raised every IDLE cycle → grant order D,D,I,D,D,I; streak returns to 0 after each I.
- Fetch issued at t, if_kill=1 at t+1 → if_ready stays 0 at t+2, the state returns to IDLE at t+3, and a new fetch to the redirect address issues at t+3.
- Store mem_we=1, addr=0x20, wdata=0xDEADBEEF → ram_en=ram_we=1 with those values at t; mem_ready=1 and mem_rdata=0 at t+2.
- Reset asserted at t+1 of a load → ram_*/ready outputs are 0 immediately. After release, no stale mem_ready appears, and the next request issues on the first IDLE cycle.
